// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch unit: per-request prediction
// metadata and the decode-side instruction-queue entry.
package fetch_pkg;

  localparam logic [31:0] RESET_PC = 32'h1eceb000;

  typedef struct packed {
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        kill;
  } fetch_meta_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred_taken;
    logic [31:0] pred_target;
  } iq_entry_t;

endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO with show-ahead head and synchronous flush; DEPTH must be a
// power of two. The caller guarantees no push when full (unless also popping) and no pop when empty.
module fifo_sync #(
  parameter type         T     = logic [31:0],
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  output T                         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  T             mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Full with push+pop writes the slot being read out this cycle, which becomes the new tail.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_pred_ctrl.sv
// Fetch-side initiator of the IFU<->BPU prediction protocol: owns the fetch PC,
// issues in-order imem requests, steers on predictions. Macro FETCH_BTB_HIT_TAKEN_EN: BTB hit alone means taken.
module fetch_pred_ctrl #(
  parameter int unsigned QUEUE_DEPTH     = 8,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter logic [31:0] RESET_PC        = fetch_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        bpu_fetch,
  output logic [31:0] bpu_fetch_pc,
  input  logic        bpu_predict_taken,
  input  logic        bpu_predict_valid,
  input  logic [31:0] bpu_predict_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        iq_valid,
  input  logic        iq_ready,
  output logic [31:0] iq_pc,
  output logic [31:0] iq_inst,
  output logic        iq_pred_taken,
  output logic [31:0] iq_pred_target
);

  import fetch_pkg::*;

  localparam int unsigned CW = $clog2(QUEUE_DEPTH + MAX_OUTSTANDING + 1);
  localparam int unsigned QW = $clog2(QUEUE_DEPTH);
  localparam int unsigned MW = $clog2(MAX_OUTSTANDING);

  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_nxt;
  logic [CW-1:0] drop_cnt;
  logic          s1_valid;
  logic          s1_kill;
  logic [31:0]   s1_pc;

  logic [QW:0]   iq_count;
  logic [MW:0]   meta_count;
  logic [CW:0]   reserved;

  fetch_meta_t   meta_in;
  fetch_meta_t   meta_head;
  fetch_meta_t   resp_meta;
  iq_entry_t     iq_in;
  iq_entry_t     iq_head;

  logic accept;
  logic pred_raw;
  logic s1_taken;
  logic drop_resp;
  logic resp_live;
  logic meta_bypass;
  logic meta_push;
  logic meta_pop;
  logic iq_push;
  logic iq_pop;

`ifdef FETCH_BTB_HIT_TAKEN_EN
  assign pred_raw = bpu_predict_valid;
`else
  assign pred_raw = bpu_predict_valid && bpu_predict_taken;
`endif

  // Outstanding requests reserve IQ space so a returning response always has a slot.
  assign reserved = {1'b0, outstanding} + (CW+1)'(iq_count);

  always_comb begin
    imem_req = !rst && !redirect
               && (reserved < (CW+1)'(QUEUE_DEPTH))
               && (outstanding < CW'(MAX_OUTSTANDING));
    accept   = imem_req && imem_gnt;
    s1_taken = s1_valid && !s1_kill && pred_raw;
    meta_in  = '{pc: s1_pc, pred_taken: s1_taken, pred_target: bpu_predict_pc, kill: s1_kill};

    drop_resp = imem_rvalid && (drop_cnt != '0);
    resp_live = imem_rvalid && (drop_cnt == '0);
    // Memory latency is at least one cycle, so a response meeting an empty
    // metadata FIFO belongs to the request whose prediction is arriving now.
    meta_bypass = resp_live && (meta_count == '0);
    resp_meta   = meta_bypass ? meta_in : meta_head;

    meta_push = s1_valid && !redirect && !meta_bypass;
    meta_pop  = resp_live && !meta_bypass && !redirect;
    iq_push   = resp_live && !redirect && !resp_meta.kill;
    iq_pop    = iq_ready && iq_valid && !redirect;
    iq_in     = '{pc: resp_meta.pc, inst: imem_rdata,
                  pred_taken: resp_meta.pred_taken, pred_target: resp_meta.pred_target};

    outstanding_nxt = outstanding + CW'(accept) - CW'(imem_rvalid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      s1_valid    <= 1'b0;
      s1_kill     <= 1'b0;
      s1_pc       <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      s1_pc       <= pc;
      if (redirect) begin
        pc       <= redirect_pc;
        drop_cnt <= outstanding_nxt;
        s1_valid <= 1'b0;
        s1_kill  <= 1'b0;
      end else begin
        s1_valid <= accept;
        s1_kill  <= accept && s1_taken;
        if (s1_taken)
          pc <= bpu_predict_pc;
        else if (accept)
          pc <= pc + 32'd4;
        if (drop_resp)
          drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  fifo_sync #(
    .T     (fetch_meta_t),
    .DEPTH (MAX_OUTSTANDING)
  ) u_meta_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (meta_push),
    .push_data (meta_in),
    .pop       (meta_pop),
    .head      (meta_head),
    .count     (meta_count)
  );

  fifo_sync #(
    .T     (iq_entry_t),
    .DEPTH (QUEUE_DEPTH)
  ) u_iq_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (iq_push),
    .push_data (iq_in),
    .pop       (iq_pop),
    .head      (iq_head),
    .count     (iq_count)
  );

  always_comb begin
    imem_addr      = imem_req ? pc : '0;
    bpu_fetch      = accept;
    bpu_fetch_pc   = imem_addr;
    iq_valid       = (iq_count != '0);
    iq_pc          = iq_valid ? iq_head.pc : '0;
    iq_inst        = iq_valid ? iq_head.inst : '0;
    iq_pred_taken  = iq_valid && iq_head.pred_taken;
    iq_pred_target = iq_valid ? iq_head.pred_target : '0;
  end

endmodule

// File: tb/tb_fetch_pred_ctrl.sv
// Self-checking bench for fetch_pred_ctrl: table-driven startup vectors, directed
// corner sequences, and randomized traffic against a queue-based reference model.
module tb_fetch_pred_ctrl;

  localparam int unsigned QD  = 8;
  localparam int unsigned MO  = 4;
  localparam logic [31:0] RPC = 32'h1eceb000;
`ifdef FETCH_BTB_HIT_TAKEN_EN
  localparam bit HIT_TAKEN = 1'b1;
`else
  localparam bit HIT_TAKEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        bpu_fetch;
  logic [31:0] bpu_fetch_pc;
  logic        bpu_predict_taken;
  logic        bpu_predict_valid;
  logic [31:0] bpu_predict_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        iq_valid;
  logic        iq_ready;
  logic [31:0] iq_pc;
  logic [31:0] iq_inst;
  logic        iq_pred_taken;
  logic [31:0] iq_pred_target;

  always #5 clk = ~clk;

  fetch_pred_ctrl #(
    .QUEUE_DEPTH     (QD),
    .MAX_OUTSTANDING (MO),
    .RESET_PC        (RPC)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .bpu_fetch         (bpu_fetch),
    .bpu_fetch_pc      (bpu_fetch_pc),
    .bpu_predict_taken (bpu_predict_taken),
    .bpu_predict_valid (bpu_predict_valid),
    .bpu_predict_pc    (bpu_predict_pc),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_gnt          (imem_gnt),
    .imem_rvalid       (imem_rvalid),
    .imem_rdata        (imem_rdata),
    .redirect          (redirect),
    .redirect_pc       (redirect_pc),
    .iq_valid          (iq_valid),
    .iq_ready          (iq_ready),
    .iq_pc             (iq_pc),
    .iq_inst           (iq_inst),
    .iq_pred_taken     (iq_pred_taken),
    .iq_pred_target    (iq_pred_target)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory: in-order responses, each no earlier than `lat` cycles after its grant.
  typedef struct { logic [31:0] addr; int unsigned due; } mreq_t;
  mreq_t       memq[$];
  int unsigned cyc = 0;
  int unsigned lat = 1;
  bit          rv_en = 1'b1;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5a5a_0f0f;
  endfunction

  // Reference model: in-flight requests and IQ contents as plain queues.
  typedef struct { logic [31:0] pc; bit kill; bit taken; logic [31:0] tgt; bit dropped; } rec_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; bit taken; logic [31:0] tgt; } iqe_t;
  rec_t        infl[$];
  iqe_t        miq[$];
  logic [31:0] mpc = RPC;
  bit          s1_pend = 1'b0;
  bit          exp_req;

  function automatic bit pred_rule(input bit v, input bit t);
`ifdef FETCH_BTB_HIT_TAKEN_EN
    return v;
`else
    return v && t;
`endif
  endfunction

  task automatic tick_begin();
    imem_rvalid = rv_en && (memq.size() > 0) && (memq[0].due <= cyc);
    imem_rdata  = imem_rvalid ? inst_of(memq[0].addr) : $urandom;
    @(negedge clk);
    exp_req = !redirect && (infl.size() + miq.size() < QD) && (infl.size() < MO);
    chk("imem_req", imem_req, exp_req);
    if (exp_req) chk("imem_addr", imem_addr, mpc);
    chk("bpu_fetch", bpu_fetch, exp_req && imem_gnt);
    if (exp_req && imem_gnt) chk("bpu_fetch_pc", bpu_fetch_pc, mpc);
    chk("iq_valid", iq_valid, miq.size() > 0);
    if (miq.size() > 0) begin
      chk("iq_pc", iq_pc, miq[0].pc);
      chk("iq_inst", iq_inst, miq[0].inst);
      chk("iq_pred_taken", iq_pred_taken, miq[0].taken);
      chk("iq_pred_target", iq_pred_target, miq[0].tgt);
    end
  endtask

  task automatic tick_end();
    bit   acc, taken_eff, pop_iq;
    rec_t r;
    acc       = exp_req && imem_gnt;
    taken_eff = 1'b0;
    pop_iq    = iq_ready && (miq.size() > 0);
    if (redirect) begin
      if (imem_rvalid && infl.size() > 0) void'(infl.pop_front());
      foreach (infl[i]) infl[i].dropped = 1'b1;
      miq.delete();
      mpc     = redirect_pc;
      s1_pend = 1'b0;
    end else begin
      if (s1_pend && infl.size() > 0) begin
        r = infl[infl.size()-1];
        if (!r.kill) r.taken = pred_rule(bpu_predict_valid, bpu_predict_taken);
        r.tgt     = bpu_predict_pc;
        taken_eff = r.taken;
        infl[infl.size()-1] = r;
      end
      if (pop_iq) void'(miq.pop_front());
      if (imem_rvalid && infl.size() > 0) begin
        r = infl.pop_front();
        if (!r.dropped && !r.kill) miq.push_back('{r.pc, inst_of(r.pc), r.taken, r.tgt});
      end
      if (acc) infl.push_back('{mpc, taken_eff, 1'b0, 32'h0, 1'b0});
      s1_pend = acc;
      if (taken_eff)  mpc = bpu_predict_pc;
      else if (acc)   mpc = mpc + 32'd4;
    end
    if (imem_rvalid && memq.size() > 0) void'(memq.pop_front());
    if (imem_req && imem_gnt) memq.push_back('{imem_addr, cyc + lat});
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    tick_begin();
    tick_end();
  endtask

  task automatic quiesce();
    imem_gnt = 1'b0; redirect = 1'b0; iq_ready = 1'b1; rv_en = 1'b1;
    bpu_predict_valid = 1'b0; bpu_predict_taken = 1'b0; bpu_predict_pc = '0;
    for (int i = 0; i < 60; i++) begin
      if (infl.size() == 0 && miq.size() == 0 && memq.size() == 0) break;
      tick();
    end
    chk("quiesce_pending", infl.size() + miq.size() + memq.size(), 0);
  endtask

  task automatic wait_iq(input string name, input logic [31:0] exp_pc);
    bit seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick_begin();
      if (iq_valid) begin
        seen = 1'b1;
        chk({name, ".pc"}, iq_pc, exp_pc);
      end
      tick_end();
    end
    if (!seen) chk({name, ".timeout_iq_valid"}, 32'd0, 32'd1);
  endtask

  typedef struct {
    bit gnt; bit bv; bit bt; logic [31:0] bpc;
    bit e_req; logic [31:0] e_addr; bit e_iqv; logic [31:0] e_iqpc; bit e_tk; logic [31:0] e_tgt;
  } vec_t;
  vec_t vt[7];

  initial begin
    int n_acc;

    vt[0] = '{1, 0, 0, 32'h0,        1, 32'h1eceb000, 0, 32'h0,        0, 32'h0};
    vt[1] = '{1, 0, 0, 32'h0,        1, 32'h1eceb004, 0, 32'h0,        0, 32'h0};
    vt[2] = '{1, 1, 1, 32'h1eceb100, 1, 32'h1eceb008, 1, 32'h1eceb000, 0, 32'h0};
    vt[3] = '{1, 0, 0, 32'h0,        1, 32'h1eceb100, 1, 32'h1eceb004, 1, 32'h1eceb100};
    vt[4] = '{1, 0, 0, 32'h0,        1, 32'h1eceb104, 0, 32'h0,        0, 32'h0};
    vt[5] = '{1, 0, 0, 32'h0,        1, 32'h1eceb108, 1, 32'h1eceb100, 0, 32'h0};
    vt[6] = '{1, 0, 0, 32'h0,        1, 32'h1eceb10c, 1, 32'h1eceb104, 0, 32'h0};

    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; iq_ready = 1'b1;
    bpu_predict_valid = 1'b0; bpu_predict_taken = 1'b0; bpu_predict_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.imem_req", imem_req, 0);
    chk("rst.imem_addr", imem_addr, 0);
    chk("rst.bpu_fetch", bpu_fetch, 0);
    chk("rst.bpu_fetch_pc", bpu_fetch_pc, 0);
    chk("rst.iq_valid", iq_valid, 0);
    chk("rst.iq_pc", iq_pc, 0);
    chk("rst.iq_inst", iq_inst, 0);
    chk("rst.iq_pred", {iq_pred_taken, iq_pred_target}, 0);
    rst = 1'b0;

    // Sequential fetch, then a taken BTB hit at ...004 with its wrong-path ...008 killed.
    for (int i = 0; i < 7; i++) begin
      imem_gnt = vt[i].gnt; iq_ready = 1'b1;
      bpu_predict_valid = vt[i].bv; bpu_predict_taken = vt[i].bt; bpu_predict_pc = vt[i].bpc;
      tick_begin();
      chk($sformatf("vec%0d.req", i), imem_req, vt[i].e_req);
      chk($sformatf("vec%0d.addr", i), imem_addr, vt[i].e_addr);
      chk($sformatf("vec%0d.iq_valid", i), iq_valid, vt[i].e_iqv);
      if (vt[i].e_iqv) begin
        chk($sformatf("vec%0d.iq_pc", i), iq_pc, vt[i].e_iqpc);
        chk($sformatf("vec%0d.iq_tk", i), iq_pred_taken, vt[i].e_tk);
        chk($sformatf("vec%0d.iq_tgt", i), iq_pred_target, vt[i].e_tgt);
      end
      tick_end();
    end
    quiesce();

    // BTB hit with PHT not-taken.
    redirect = 1'b1; redirect_pc = 32'h1eceb400; tick();
    redirect = 1'b0; imem_gnt = 1'b1; tick();
    imem_gnt = 1'b0;
    bpu_predict_valid = 1'b1; bpu_predict_taken = 1'b0; bpu_predict_pc = 32'h1eceb500; tick();
    bpu_predict_valid = 1'b0; bpu_predict_pc = '0;
    tick_begin();
    chk("hit_nt.iq_pc", iq_pc, 32'h1eceb400);
    chk("hit_nt.pred_taken", iq_pred_taken, HIT_TAKEN);
    chk("hit_nt.pred_target", iq_pred_target, 32'h1eceb500);
    chk("hit_nt.next_addr", imem_addr, HIT_TAKEN ? 32'h1eceb500 : 32'h1eceb404);
    tick_end();
    quiesce();

    // Three outstanding, then redirect: all three responses are discarded.
    rv_en = 1'b0; imem_gnt = 1'b1;
    repeat (3) tick();
    imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h1eceb200;
    tick_begin(); chk("flush3.req_during_redirect", imem_req, 0); tick_end();
    redirect = 1'b0; rv_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick_begin();
      chk($sformatf("flush3.iq_empty%0d", i), iq_valid, 0);
      if (i == 0) chk("flush3.resume_addr", imem_addr, 32'h1eceb200);
      tick_end();
    end
    imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
    wait_iq("flush3.first", 32'h1eceb200);
    quiesce();

    // Backpressure: reservation limits accepts to QUEUE_DEPTH; one pop frees exactly one.
    iq_ready = 1'b0; imem_gnt = 1'b1; n_acc = 0;
    for (int i = 0; i < 20; i++) begin
      tick_begin(); if (imem_req && imem_gnt) n_acc++; tick_end();
    end
    chk("bp.accepts_full", n_acc, QD);
    tick_begin(); chk("bp.req_low", imem_req, 0); tick_end();
    n_acc = 0; iq_ready = 1'b1;
    tick_begin(); if (imem_req && imem_gnt) n_acc++; tick_end();
    iq_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick_begin(); if (imem_req && imem_gnt) n_acc++; tick_end();
    end
    chk("bp.accepts_after_pop", n_acc, 1);
    quiesce();

    // Redirect with gnt and rvalid in the same cycle; both owed responses are dropped.
    lat = 2; imem_gnt = 1'b1;
    tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h1eceb600;
    tick_begin();
    chk("same.rvalid_present", imem_rvalid, 1);
    chk("same.no_accept", bpu_fetch, 0);
    tick_end();
    redirect = 1'b0; imem_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick_begin(); chk($sformatf("same.iq_empty%0d", i), iq_valid, 0); tick_end();
    end
    lat = 1; imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
    wait_iq("same.first", 32'h1eceb600);
    quiesce();

    // Randomized traffic, including PC wrap-around targets.
    for (int i = 0; i < 1500; i++) begin
      imem_gnt          = ($urandom_range(0, 3) != 0);
      iq_ready          = ($urandom_range(0, 2) != 0);
      rv_en             = ($urandom_range(0, 4) != 0);
      lat               = $urandom_range(1, 4);
      bpu_predict_valid = $urandom_range(0, 1);
      bpu_predict_taken = $urandom_range(0, 1);
      bpu_predict_pc    = ($urandom_range(0, 7) == 0) ? 32'hfffffff8
                                                      : RPC + ($urandom_range(0, 255) << 2);
      redirect          = ($urandom_range(0, 39) == 0);
      redirect_pc       = ($urandom_range(0, 3) == 0) ? 32'hfffffff4
                                                      : RPC + ($urandom_range(0, 255) << 2);
      tick();
    end
    quiesce();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
